// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: regfile read with same-cycle writeback bypass,
// load-use bubble insertion, flush/hold handling and a saturating bubble counter.
module id_ex_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_mem_read,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   rf_rs1_data,
  input  logic [XLEN-1:0]   rf_rs2_data,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic              ex_mem_read,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  bubble_count
);

  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            lu;

  // The regfile writes at the edge, so a same-cycle read still returns the old value.
  always_comb begin
    op1 = rf_rs1_data;
    op2 = rf_rs2_data;
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == id_rs1)) op1 = wb_data;
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == id_rs2)) op2 = wb_data;
  end

  always_comb begin
    lu = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
         ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    id_stall = !flush && (ex_hold || lu);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_imm       <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_mem_read  <= 1'b0;
      ex_ctrl      <= '0;
      bubble_count <= '0;
    end else if (flush) begin
      ex_valid    <= 1'b0;
      ex_mem_read <= 1'b0;
    end else if (!ex_hold) begin
      if (lu) begin
        ex_valid    <= 1'b0;
        ex_mem_read <= 1'b0;
        ex_rd       <= '0;
        if (bubble_count != '1) bubble_count <= bubble_count + CNT_W'(1);
      end else begin
        ex_valid    <= id_valid;
        ex_pc       <= id_pc;
        ex_imm      <= id_imm;
        ex_rs1_data <= op1;
        ex_rs2_data <= op2;
        ex_rs1      <= id_rs1;
        ex_rs2      <= id_rs2;
        ex_rd       <= id_rd;
        ex_mem_read <= id_mem_read;
        ex_ctrl     <= id_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, checked against an architectural register-file/pipeline model.
module tb_id_ex_stage;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int          CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid, id_use_rs1, id_use_rs2, id_mem_read;
  logic [XLEN-1:0]   id_pc, id_imm, rf_rs1_data, rf_rs2_data, wb_data;
  logic [4:0]        id_rs1, id_rs2, id_rd, wb_rd;
  logic [CTRL_W-1:0] id_ctrl;
  logic              wb_we, flush, ex_hold;
  logic              id_stall, ex_valid, ex_mem_read;
  logic [XLEN-1:0]   ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  bubble_count;

  id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_imm(id_imm), .id_mem_read(id_mem_read), .id_ctrl(id_ctrl),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .flush(flush), .ex_hold(ex_hold), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_ctrl(ex_ctrl), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural register file; x0 is never written.
  logic [XLEN-1:0] regs [32];

  // Expected EX-side state. dc flags mark fields whose value is not defined.
  bit              m_init = 0;
  bit              m_dc, m_rd_dc;
  bit              m_valid, m_mr;
  logic [XLEN-1:0] m_pc, m_imm, m_op1, m_op2;
  logic [4:0]      m_rs1, m_rs2, m_rd;
  logic [CTRL_W-1:0] m_ctrl;
  int              m_cnt;

  function automatic bit model_lu();
    if (!(id_valid && m_valid && m_mr && m_rd != 0)) return 0;
    return (id_use_rs1 && id_rs1 == m_rd) || (id_use_rs2 && id_rs2 == m_rd);
  endfunction

  task automatic settle();
    rf_rs1_data = regs[id_rs1];
    rf_rs2_data = regs[id_rs2];
    #1;
    if (m_init && !rst)
      check_val("id_stall", 64'(id_stall), 64'(!flush && (ex_hold || model_lu())));
  endtask

  task automatic clock();
    logic [XLEN-1:0] nxt [32];
    nxt = regs;
    if (wb_we && wb_rd != 0) nxt[wb_rd] = wb_data;
    if (rst) begin
      m_init = 1; m_dc = 0; m_rd_dc = 0; m_valid = 0; m_mr = 0;
      m_pc = 0; m_imm = 0; m_op1 = 0; m_op2 = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
      m_ctrl = 0; m_cnt = 0;
    end else if (!m_init) begin
    end else if (flush) begin
      m_valid = 0; m_mr = 0; m_dc = 1; m_rd_dc = 1;
    end else if (ex_hold) begin
    end else if (model_lu()) begin
      m_valid = 0; m_mr = 0; m_rd = 0; m_rd_dc = 0; m_dc = 1;
      m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
    end else begin
      m_valid = id_valid; m_mr = id_mem_read; m_pc = id_pc; m_imm = id_imm;
      m_op1 = nxt[id_rs1]; m_op2 = nxt[id_rs2];
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_ctrl = id_ctrl;
      m_dc = 0; m_rd_dc = 0;
    end
    @(posedge clk);
    regs = nxt;
    #1;
    if (m_init) begin
      check_val("ex_valid", 64'(ex_valid), 64'(m_valid));
      check_val("ex_mem_read", 64'(ex_mem_read), 64'(m_mr));
      check_val("bubble_count", 64'(bubble_count), 64'(m_cnt));
      if (!m_rd_dc) check_val("ex_rd", 64'(ex_rd), 64'(m_rd));
      if (!m_dc) begin
        check_val("ex_pc", 64'(ex_pc), 64'(m_pc));
        check_val("ex_imm", 64'(ex_imm), 64'(m_imm));
        check_val("ex_rs1_data", 64'(ex_rs1_data), 64'(m_op1));
        check_val("ex_rs2_data", 64'(ex_rs2_data), 64'(m_op2));
        check_val("ex_rs1", 64'(ex_rs1), 64'(m_rs1));
        check_val("ex_rs2", 64'(ex_rs2), 64'(m_rs2));
        check_val("ex_ctrl", 64'(ex_ctrl), 64'(m_ctrl));
      end
    end
  endtask

  task automatic step();
    settle();
    clock();
  endtask

  task automatic set_id(input logic v, input logic [XLEN-1:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic [4:0] rd, input logic mr);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1;
    id_use_rs2 = u2; id_rd = rd; id_mem_read = mr; id_imm = pc + 32'h4; id_ctrl = pc[7:0];
  endtask

  function automatic logic [4:0] pick_reg();
    int unsigned r = $urandom_range(0, 4);
    return (r == 4) ? 5'd7 : 5'(r);
  endfunction

  task automatic do_reset();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  int saved_cnt;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    rst = 1; flush = 0; ex_hold = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
    set_id(1, 32'h40, 5'd1, 5'd2, 1, 1, 5'd3, 0);

    // Reset with a valid instruction presented
    do_reset();
    check_val("rst_ex_valid", 64'(ex_valid), 64'd0);
    check_val("rst_bubble", 64'(bubble_count), 64'd0);
    check_val("rst_ex_pc", 64'(ex_pc), 64'd0);
    settle();
    check_val("rst_id_stall", 64'(id_stall), 64'd0);
    clock();

    // Writeback bypass, then x0 never bypassed
    wb_we = 1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    set_id(1, 32'h100, 5'd5, 5'd0, 1, 0, 5'd6, 0);
    step();
    check_val("bypass_rs1", 64'(ex_rs1_data), 64'hDEADBEEF);
    wb_rd = 5'd0;
    set_id(1, 32'h104, 5'd0, 5'd0, 1, 0, 5'd6, 0);
    step();
    check_val("bypass_x0", 64'(ex_rs1_data), 64'd0);
    wb_we = 0;

    // Load-use: lw x7 then add reading x7 via rs2
    set_id(1, 32'h200, 5'd1, 5'd2, 1, 0, 5'd7, 1);
    step();
    check_val("lw_mem_read", 64'(ex_mem_read), 64'd1);
    check_val("lw_rd", 64'(ex_rd), 64'd7);
    set_id(1, 32'h204, 5'd3, 5'd7, 1, 1, 5'd8, 0);
    settle();
    check_val("lu_stall", 64'(id_stall), 64'd1);
    clock();
    check_val("lu_bubble", 64'(ex_valid), 64'd0);
    check_val("lu_count", 64'(bubble_count), 64'd1);
    settle();
    check_val("lu_stall_drop", 64'(id_stall), 64'd0);
    clock();
    check_val("lu_add_pc", 64'(ex_pc), 64'h204);
    check_val("lu_add_valid", 64'(ex_valid), 64'd1);
    set_id(1, 32'h208, 5'd1, 5'd2, 1, 0, 5'd7, 1);
    step();
    set_id(1, 32'h20C, 5'd3, 5'd7, 1, 0, 5'd8, 0);
    settle();
    check_val("no_use_stall", 64'(id_stall), 64'd0);
    clock();
    check_val("no_use_count", 64'(bubble_count), 64'd1);

    // Flush overrides hold and load-use
    set_id(1, 32'h300, 5'd1, 5'd2, 1, 0, 5'd7, 1);
    step();
    set_id(1, 32'h304, 5'd7, 5'd2, 1, 0, 5'd8, 0);
    ex_hold = 1; flush = 1; saved_cnt = m_cnt;
    settle();
    check_val("flush_stall", 64'(id_stall), 64'd0);
    clock();
    check_val("flush_valid", 64'(ex_valid), 64'd0);
    check_val("flush_count", 64'(bubble_count), 64'(saved_cnt));
    ex_hold = 0; flush = 0;

    // Hold for 3 cycles while ID changes, then capture
    set_id(1, 32'h400, 5'd1, 5'd2, 1, 1, 5'd9, 0);
    step();
    ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 32'h500 + 32'(i), 5'd3, 5'd4, 1, 1, 5'd10, 0);
      step();
      check_val("hold_pc", 64'(ex_pc), 64'h400);
    end
    ex_hold = 0;
    step();
    check_val("release_pc", 64'(ex_pc), 64'h502);

    // Saturation: 17 bubbles from a self-dependent load chain
    do_reset();
    set_id(1, 32'h600, 5'd1, 5'd7, 0, 1, 5'd7, 1);
    for (int i = 0; i < 34; i++) step();
    check_val("sat_count", 64'(bubble_count), 64'(CMAX));

    // Random traffic
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? '0 : $urandom;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      set_id($urandom_range(0, 3) != 0, $urandom, pick_reg(), pick_reg(),
             1'($urandom), 1'($urandom), pick_reg(), 1'($urandom));
      id_imm = $urandom; id_ctrl = 8'($urandom);
      wb_we = 1'($urandom); wb_rd = pick_reg(); wb_data = $urandom;
      flush = ($urandom_range(0, 7) == 0);
      ex_hold = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
